// File: rtl/fetch_unit.sv
// Line-based instruction fetch engine: requests whole lines, unpacks beats into a FIFO.
// Define FETCH_TRACE_EN to print requests, redirects and discarded beats.
module fetch_unit #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int LINE_BEATS = 8,
  parameter int FIFO_DEPTH = 32,
  parameter logic [BUS_TAG_WIDTH-1:0] REQ_TAG = 13'h1100
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [63:0]               entry,
  input  logic                      redirect,
  input  logic [63:0]               redirect_pc,
  output logic                      bus_reqcyc,
  output logic [63:0]               bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      bus_respack,
  output logic                      inst_valid,
  output logic [31:0]               inst,
  output logic [63:0]               inst_pc,
  input  logic                      inst_ready,
  output logic                      busy
);

  localparam int LINE_BYTES = LINE_BEATS * 8;
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] ROOM_C = CNT_W'(2 * LINE_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
  localparam logic [63:0] LINE_STEP = 64'(LINE_BYTES);
  localparam logic [63:0] LINE_MASK = ~(LINE_STEP - 64'd1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DISCARD} state_t;

  state_t state_q, state_d;

  logic [63:0]       fetch_pc;
  logic [63:0]       req_addr;
  logic [BEAT_W-1:0] beat_cnt;
  logic              drop_q;
  logic [31:0]       fifo_inst [FIFO_DEPTH];
  logic [63:0]       fifo_pc [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, wr_hi;
  logic [CNT_W-1:0]  count, free_cnt, n_push;

  logic load_req, ack_req, beat_take, push_beat, line_done;
  logic last_beat, push_lo, push_hi, pop;
  logic [63:0] lo_addr, hi_addr;

  // Handshakes: a request transfers on bus_reqcyc & bus_reqack, a response beat on
  // bus_respcyc & bus_respack, and an instruction pops on inst_valid & inst_ready.
  assign bus_reqcyc  = (state_q == REQ);
  assign bus_req     = bus_reqcyc ? req_addr : '0;
  assign bus_reqtag  = bus_reqcyc ? REQ_TAG : '0;
  assign bus_respack = bus_respcyc && ((state_q == RESP) || (state_q == DISCARD));
  assign busy        = (state_q != IDLE);

  assign inst_valid = (count != '0);
  assign inst       = inst_valid ? fifo_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : '0;
  assign pop        = inst_valid && inst_ready;
  assign free_cnt   = DEPTH_C - count;

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign lo_addr   = req_addr | {{(64-OFF_W){1'b0}}, beat_cnt, 3'b000};
  assign hi_addr   = lo_addr | 64'd4;
  // Words below fetch_pc belong to the part of the line before the entry point.
  assign push_lo   = push_beat && (lo_addr >= fetch_pc);
  assign push_hi   = push_beat && (hi_addr >= fetch_pc);
  assign n_push    = CNT_W'(push_lo) + CNT_W'(push_hi);
  assign wr_hi     = wr_ptr + PTR_W'(push_lo);

  logic unused_bits;
  assign unused_bits = ^{bus_resptag, redirect_pc[1:0]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_req  = 1'b0;
    ack_req   = 1'b0;
    beat_take = 1'b0;
    push_beat = 1'b0;
    line_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect && (free_cnt >= ROOM_C)) begin
          state_d  = REQ;
          load_req = 1'b1;
        end
      end
      REQ: begin
        if (bus_reqack) begin
          ack_req = 1'b1;
          state_d = (redirect || drop_q) ? DISCARD : RESP;
        end
      end
      RESP: begin
        if (bus_respcyc) begin
          beat_take = 1'b1;
          push_beat = !redirect;
          if (last_beat) begin
            state_d   = IDLE;
            line_done = !redirect;
          end else if (redirect) begin
            state_d = DISCARD;
          end
        end else if (redirect) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (bus_respcyc) begin
          beat_take = 1'b1;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= entry;
      req_addr <= '0;
      beat_cnt <= '0;
      drop_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (load_req) req_addr <= fetch_pc & LINE_MASK;
      if (redirect)       fetch_pc <= {redirect_pc[63:2], 2'b00};
      else if (line_done) fetch_pc <= req_addr + LINE_STEP;
      if (ack_req)        beat_cnt <= '0;
      else if (beat_take) beat_cnt <= beat_cnt + BEAT_W'(1);
      // A redirect seen while the request is still pending poisons that line.
      drop_q <= (state_q == REQ) && !bus_reqack && (drop_q || redirect);
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(n_push);
        rd_ptr <= rd_ptr + PTR_W'(pop);
        count  <= count + n_push - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_lo) begin
      fifo_inst[wr_ptr] <= bus_resp[31:0];
      fifo_pc[wr_ptr]   <= lo_addr;
    end
    if (push_hi) begin
      fifo_inst[wr_hi] <= bus_resp[63:32];
      fifo_pc[wr_hi]   <= hi_addr;
    end
  end

`ifdef FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ack_req) $display("fetch req @ %x", req_addr);
      if (redirect) $display("redirect -> %x", {redirect_pc[63:2], 2'b00});
      if (beat_take && !push_beat) $display("fetch discard beat %0d", beat_cnt);
    end
  end
`else
  // Normal builds carry no trace output.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_unit;
  localparam int LINE_BEATS = 8;
  localparam int FIFO_DEPTH = 32;
  localparam logic [63:0] LINE_MASK = ~64'(LINE_BEATS * 8 - 1);

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        bus_respack;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_ready;
  logic        busy;

  fetch_unit dut (
    .clk(clk), .reset(reset), .entry(entry), .redirect(redirect), .redirect_pc(redirect_pc),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;

  // scoreboard: expected PCs of buffered instructions, plus fetch model state
  logic [63:0] exp_q[$];
  logic [63:0] m_fetch_pc, m_req_addr, m_line_base;
  bit          m_req_out, m_drop, m_keep;
  int          m_beats_left, m_beat;

  // memory responder and logs
  bit          rsp_on;
  logic [63:0] rsp_base;
  int          rsp_beat;
  logic [63:0] req_log[$];
  logic [63:0] pop_log[$];
  logic [12:0] last_tag;

  // stimulus knobs
  int          ack_pct = 100, resp_pct = 100, ready_pct = 100, redir_pct = 0, stray_pct = 0;
  bit          redir_beat3 = 0, redir_once = 0;
  logic [63:0] redir_target = 64'h0;

  function automatic logic [31:0] word(input logic [63:0] addr);
    return addr[31:0];
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_fetch_pc   = entry;
    m_req_out    = 0;
    m_drop       = 0;
    m_keep       = 0;
    m_beats_left = 0;
    m_beat       = 0;
    rsp_on       = 0;
  endfunction

  function automatic logic [63:0] pick_pc();
    case ($urandom_range(0, 3))
      0: return 64'h1000 + 64'($urandom_range(0, 1023));
      1: return 64'hFFFF_FFFF_FFFF_FF80 + 64'($urandom_range(0, 127));
      2: return {32'($urandom), 32'($urandom)};
      default: return 64'h2000 + 64'($urandom_range(0, 255));
    endcase
  endfunction

  // One clock cycle: compare, drive, then advance the model with the driven inputs.
  task automatic step(input bit do_rst);
    logic [63:0] head, lo;
    int          free_before;
    bit          do_pop;
    @(negedge clk);
    head = (exp_q.size() > 0) ? exp_q[0] : 64'h0;
    check64("bus_reqcyc", 64'(bus_reqcyc), 64'(m_req_out));
    check64("bus_req", bus_req, m_req_out ? m_req_addr : 64'h0);
    check64("bus_reqtag", 64'(bus_reqtag), m_req_out ? 64'h1100 : 64'h0);
    check64("busy", 64'(busy), 64'(m_req_out || (m_beats_left > 0)));
    check64("inst_valid", 64'(inst_valid), 64'(exp_q.size() > 0));
    check64("inst_pc", inst_pc, head);
    check64("inst", 64'(inst), (exp_q.size() > 0) ? 64'(word(head)) : 64'h0);

    reset       = do_rst;
    inst_ready  = ($urandom_range(0, 99) < ready_pct);
    bus_reqack  = ($urandom_range(0, 99) < ack_pct);
    bus_resptag = 13'($urandom);
    if (rsp_on) begin
      bus_respcyc = ($urandom_range(0, 99) < resp_pct);
      lo = rsp_base + 64'(8 * rsp_beat);
      bus_resp = {word(lo + 64'd4), word(lo)};
    end else begin
      bus_respcyc = ($urandom_range(0, 99) < stray_pct);
      bus_resp = {32'($urandom), 32'($urandom)};
    end
    redirect    = 1'b0;
    redirect_pc = 64'($urandom);
    if (redir_once) begin
      redirect = 1'b1;
      redirect_pc = redir_target;
      redir_once = 0;
    end else if (redir_beat3 && rsp_on && (rsp_beat == 3) && bus_respcyc) begin
      redirect = 1'b1;
      redirect_pc = redir_target;
      redir_beat3 = 0;
    end else if ($urandom_range(0, 99) < redir_pct) begin
      redirect = 1'b1;
      redirect_pc = pick_pc();
    end
    #1;
    check64("bus_respack", 64'(bus_respack), 64'(bus_respcyc && (m_beats_left > 0)));

    if (do_rst) begin
      model_reset();
    end else begin
      if (bus_reqcyc && bus_reqack) begin
        req_log.push_back(bus_req);
        last_tag = bus_reqtag;
        rsp_on = 1;
        rsp_base = bus_req;
        rsp_beat = 0;
      end else if (rsp_on && bus_respcyc && bus_respack) begin
        rsp_beat++;
        if (rsp_beat == LINE_BEATS) rsp_on = 0;
      end
      if (inst_valid && inst_ready && !redirect) pop_log.push_back(inst_pc);

      free_before = FIFO_DEPTH - exp_q.size();
      do_pop = (exp_q.size() > 0) && inst_ready;
      if (redirect) exp_q.delete();
      else if (do_pop) void'(exp_q.pop_front());
      if (m_req_out) begin
        if (bus_reqack) begin
          m_req_out    = 0;
          m_beats_left = LINE_BEATS;
          m_beat       = 0;
          m_keep       = !(m_drop || redirect);
          m_line_base  = m_req_addr;
        end else if (redirect) begin
          m_drop = 1;
        end
      end else if (m_beats_left > 0) begin
        if (bus_respcyc) begin
          lo = m_line_base + 64'(8 * m_beat);
          if (m_keep && !redirect) begin
            if (lo >= m_fetch_pc) exp_q.push_back(lo);
            if (lo + 64'd4 >= m_fetch_pc) exp_q.push_back(lo + 64'd4);
          end
          m_beat++;
          m_beats_left--;
          if ((m_beats_left == 0) && m_keep && !redirect)
            m_fetch_pc = m_line_base + 64'(LINE_BEATS * 8);
        end
        if (redirect) m_keep = 0;
      end else if (!redirect && (free_before >= 2 * LINE_BEATS)) begin
        m_req_out  = 1;
        m_req_addr = m_fetch_pc & LINE_MASK;
        m_drop     = 0;
      end
      if (redirect) m_fetch_pc = {redirect_pc[63:2], 2'b00};
      if (exp_q.size() > FIFO_DEPTH) begin
        errors++;
        $display("FAIL fifo_overflow: model holds %0d entries, limit %0d", exp_q.size(), FIFO_DEPTH);
      end
    end
  endtask

  task automatic do_reset(input logic [63:0] e);
    entry = e;
    step(1'b1);
    req_log.delete();
    pop_log.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check64({tag, "_reqcyc"}, 64'(bus_reqcyc), 64'h0);
    check64({tag, "_req"}, bus_req, 64'h0);
    check64({tag, "_reqtag"}, 64'(bus_reqtag), 64'h0);
    check64({tag, "_respack"}, 64'(bus_respack), 64'h0);
    check64({tag, "_valid"}, 64'(inst_valid), 64'h0);
    check64({tag, "_inst"}, 64'(inst), 64'h0);
    check64({tag, "_pc"}, inst_pc, 64'h0);
    check64({tag, "_busy"}, 64'(busy), 64'h0);
  endtask

  initial begin
    int c;
    int n_low;
    reset = 1'b1; entry = 64'h1000; redirect = 1'b0; redirect_pc = 64'h0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = 64'h0; bus_resptag = 13'h0;
    inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    model_reset();

    // A: aligned entry, free-running consumer
    do_reset(64'h1000);
    c = 0;
    while ((pop_log.size() < 16 || req_log.size() < 2) && c < 200) begin step(1'b0); c++; end
    check_int("A_progress", int'(pop_log.size() >= 16 && req_log.size() >= 2), 1);
    if (req_log.size() >= 2) begin
      check64("A_req0", req_log[0], 64'h1000);
      check64("A_req1", req_log[1], 64'h1040);
    end
    check64("A_tag", 64'(last_tag), 64'h1100);
    for (int i = 0; i < 16; i++)
      if (i < pop_log.size()) check64("A_pop_pc", pop_log[i], 64'h1000 + 64'(4 * i));

    // B: mid-line entry
    do_reset(64'h1014);
    c = 0;
    while (pop_log.size() < 12 && c < 200) begin step(1'b0); c++; end
    check_int("B_progress", int'(pop_log.size() >= 12), 1);
    if (req_log.size() >= 1) check64("B_req0", req_log[0], 64'h1000);
    if (pop_log.size() >= 1) check64("B_first_pc", pop_log[0], 64'h1014);
    n_low = 0;
    foreach (pop_log[i]) if (pop_log[i] < 64'h1040) n_low++;
    check_int("B_first_line_count", n_low, 11);

    // C: stalled consumer fills the FIFO; refetch waits for a full line of room
    ready_pct = 0;
    do_reset(64'h1000);
    repeat (60) step(1'b0);
    check_int("C_two_lines", req_log.size(), 2);
    ready_pct = 100;
    repeat (15) step(1'b0);
    ready_pct = 0;
    repeat (20) step(1'b0);
    check_int("C_no_third_req", req_log.size(), 2);
    ready_pct = 100;
    step(1'b0);
    ready_pct = 0;
    repeat (6) step(1'b0);
    check_int("C_third_req", req_log.size(), 3);
    if (req_log.size() >= 3) check64("C_req2", req_log[2], 64'h1080);

    // D: redirect on beat 3 of a line
    ready_pct = 0;
    do_reset(64'h1000);
    redir_target = 64'h2008;
    redir_beat3 = 1;
    c = 0;
    while (redir_beat3 && c < 50) begin step(1'b0); c++; end
    check_int("D_redirect_fired", int'(redir_beat3), 0);
    @(posedge clk); #1;
    check64("D_flush_empty", 64'(inst_valid), 64'h0);
    c = 0;
    while (req_log.size() < 2 && c < 50) begin step(1'b0); c++; end
    ready_pct = 100;
    c = 0;
    while (pop_log.size() < 1 && c < 50) begin step(1'b0); c++; end
    check_int("D_progress", int'(req_log.size() >= 2 && pop_log.size() >= 1), 1);
    if (req_log.size() >= 2) check64("D_req1", req_log[1], 64'h2000);
    if (pop_log.size() >= 1) check64("D_first_pc", pop_log[0], 64'h2008);

    // E: redirect while the request is held unacknowledged
    ack_pct = 0;
    do_reset(64'h1000);
    repeat (3) step(1'b0);
    redir_target = 64'h4000;
    redir_once = 1;
    step(1'b0);
    repeat (2) step(1'b0);
    check64("E_req_held", bus_req, 64'h1000);
    ack_pct = 100;
    c = 0;
    while ((req_log.size() < 2 || pop_log.size() < 1) && c < 80) begin step(1'b0); c++; end
    check_int("E_progress", int'(req_log.size() >= 2 && pop_log.size() >= 1), 1);
    if (req_log.size() >= 2) begin
      check64("E_req0", req_log[0], 64'h1000);
      check64("E_req1", req_log[1], 64'h4000);
    end
    if (pop_log.size() >= 1) check64("E_first_pc", pop_log[0], 64'h4000);

    // F: reset mid-response
    ready_pct = 0;
    do_reset(64'h1000);
    c = 0;
    while (!(rsp_on && rsp_beat >= 3) && c < 50) begin step(1'b0); c++; end
    check_int("F_in_resp", int'(rsp_on), 1);
    entry = 64'h3000;
    step(1'b1);
    @(posedge clk); #1;
    check_reset_outputs("F_rst");
    req_log.delete();
    pop_log.delete();
    c = 0;
    while (req_log.size() < 1 && c < 20) begin step(1'b0); c++; end
    check_int("F_progress", int'(req_log.size() >= 1), 1);
    if (req_log.size() >= 1) check64("F_req0", req_log[0], 64'h3000);

    // G: random traffic
    ack_pct = 60; resp_pct = 70; ready_pct = 50; redir_pct = 3; stray_pct = 10;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        entry = (64'h1000 + 64'($urandom_range(0, 4095))) & ~64'h3;
        step(1'b1);
      end else begin
        step(1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
